// File: rtl/bf_pkg.sv
// Shared brainfuck-computer definitions: datapath widths, sequencer opcodes
// and the data-tape FSM state encoding.
package bf_pkg;

    localparam int BF_ADDR_W = 10;
    localparam int BF_DATA_W = 8;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_INC  = 3'd1,
        OP_DEC  = 3'd2,
        OP_OUT  = 3'd3,
        OP_IN   = 3'd4,
        OP_ZCHK = 3'd5
    } bf_op_t;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_EXEC,
        ST_OUT_WAIT,
        ST_IN_WAIT
    } tape_state_t;

endpackage

// File: rtl/bf_tape_ram.sv
// Single-port cell array: synchronous write, registered read-first output
// with one cycle of latency.
module bf_tape_ram
    import bf_pkg::*;
#(
    parameter int ADDR_W = BF_ADDR_W,
    parameter int DATA_W = BF_DATA_W,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/bf_data_tape.sv
// Data-tape stage: clears the cell array after reset, then executes
// + - . , and zero-check commands against the cell at the latched pointer address.
module bf_data_tape
    import bf_pkg::*;
#(
    parameter int ADDR_W = BF_ADDR_W,
    parameter int DATA_W = BF_DATA_W,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] r_adr,
    input  logic              cmd_valid,
    input  logic [2:0]        cmd_op,
    output logic              cmd_ready,
    output logic              done,
    output logic              zero_flag,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              in_ready,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data
);

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(DEPTH - 1);

    tape_state_t       r_state;
    tape_state_t       w_nextState;
    logic [ADDR_W-1:0] r_clrCnt;
    logic [ADDR_W-1:0] r_cellAdr;
    logic [2:0]        r_op;
    logic              r_done;
    logic              r_zero;
    logic              r_outValid;
    logic [DATA_W-1:0] r_outData;
    logic              r_inReady;

    logic              w_accept;
    logic              w_outFire;
    logic              w_inFire;
    logic              w_ramWe;
    logic [ADDR_W-1:0] w_ramAddr;
    logic [DATA_W-1:0] w_ramWdata;
    logic [DATA_W-1:0] w_rdata;

    assign cmd_ready = (r_state == ST_IDLE);
    assign w_accept  = cmd_valid & cmd_ready;
    assign w_outFire = r_outValid & out_ready;
    assign w_inFire  = r_inReady & in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_CLEAR:    if (r_clrCnt == LAST_CELL) w_nextState = ST_IDLE;
            ST_IDLE:     if (w_accept) w_nextState = ST_EXEC;
            ST_EXEC: begin
                case (r_op)
                    OP_OUT:  w_nextState = ST_OUT_WAIT;
                    OP_IN:   w_nextState = ST_IN_WAIT;
                    default: w_nextState = ST_IDLE;
                endcase
            end
            ST_OUT_WAIT: if (w_outFire) w_nextState = ST_IDLE;
            ST_IN_WAIT:  if (w_inFire) w_nextState = ST_IDLE;
            default:     w_nextState = ST_CLEAR;
        endcase
    end

    // In IDLE the RAM is addressed straight from the pointer so the read lands in EXEC.
    always_comb begin
        w_ramWe    = 1'b0;
        w_ramAddr  = r_cellAdr;
        w_ramWdata = '0;
        case (r_state)
            ST_CLEAR: begin
                w_ramWe   = 1'b1;
                w_ramAddr = r_clrCnt;
            end
            ST_IDLE: w_ramAddr = r_adr;
            ST_EXEC: begin
                if (r_op == OP_INC) begin
                    w_ramWe    = 1'b1;
                    w_ramWdata = w_rdata + DATA_W'(1);
                end else if (r_op == OP_DEC) begin
                    w_ramWe    = 1'b1;
                    w_ramWdata = w_rdata - DATA_W'(1);
                end
            end
            ST_IN_WAIT: begin
                w_ramWe    = w_inFire;
                w_ramWdata = in_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clrCnt   <= '0;
            r_cellAdr  <= '0;
            r_op       <= '0;
            r_done     <= 1'b0;
            r_zero     <= 1'b1;
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_inReady  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_CLEAR: r_clrCnt <= r_clrCnt + ADDR_W'(1);
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cellAdr <= r_adr;
                        r_op      <= cmd_op;
                    end
                end
                ST_EXEC: begin
                    case (r_op)
                        OP_OUT: begin
                            r_outData  <= w_rdata;
                            r_outValid <= 1'b1;
                        end
                        OP_IN: r_inReady <= 1'b1;
                        OP_ZCHK: begin
                            r_zero <= (w_rdata == '0);
                            r_done <= 1'b1;
                        end
                        default: r_done <= 1'b1;
                    endcase
                end
                ST_OUT_WAIT: begin
                    if (w_outFire) begin
                        r_outValid <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
                ST_IN_WAIT: begin
                    if (w_inFire) begin
                        r_inReady <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    bf_tape_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ramWe),
        .i_addr  (w_ramAddr),
        .i_wdata (w_ramWdata),
        .o_rdata (w_rdata)
    );

    assign done      = r_done;
    assign zero_flag = r_zero;
    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign in_ready  = r_inReady;

endmodule
